if_id_stage: RTL

- Instruction-fetch stage plus IF/ID pipeline register for the single-issue MIPS core.
- Holds the PC, requests instructions from instruction memory, and registers the fetched word.
- Presents opcode bits [31:26] directly to the decode-stage control unit.
- Supports hazard stall, branch redirect/flush, and memory wait (bubble insertion).

---
 rtl/if_id_stage.sv | 123 ++++++++++++
 1 files changed

// File: rtl/if_id_stage.sv
// -----------------------------------------------------------------------------
// if_id_stage
//   Instruction-fetch stage and IF/ID pipeline register for the single-issue
//   MIPS core. Owns the PC, issues fetch requests to instruction memory and
//   registers the returned word for decode. Handles hazard stalls, branch
//   redirect/flush and memory wait by inserting bubbles.
//
// Parameters
//   RESET_PC      PC value loaded on reset.
//   NOP_WORD      instruction presented while IF/ID holds a bubble.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   stall         hazard unit: freeze PC and IF/ID
//   branch_taken  branch resolved taken: redirect PC and flush IF/ID
//   branch_target redirect PC (used as-is, no alignment check)
//   imem_req      fetch request (low only in BOOT)
//   imem_addr     fetch address (current PC)
//   imem_rdata    fetched instruction word
//   imem_valid    imem_rdata valid for imem_addr this cycle
//   instr_out     registered instruction for decode
//   instr_op      instr_out[31:26], opcode to the control unit
//   pc_plus4_out  registered PC+4 of instr_out
//   id_valid      IF/ID holds a real instruction (0 = bubble)
// -----------------------------------------------------------------------------
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] instr_out,
  output logic [5:0]  instr_op,
  output logic [31:0] pc_plus4_out,
  output logic        id_valid
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] instr_nxt;
  logic [31:0] pc_plus4_nxt;
  logic        id_valid_nxt;
  logic [31:0] pc_inc;

  // 32-bit modulo increment: 32'hFFFF_FFFC wraps to 0 silently.
  assign pc_inc    = pc + 32'd4;
  assign imem_addr = pc;
  assign instr_op  = instr_out[31:26];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      instr_out    <= NOP_WORD;
      pc_plus4_out <= '0;
      id_valid     <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      instr_out    <= instr_nxt;
      pc_plus4_out <= pc_plus4_nxt;
      id_valid     <= id_valid_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    instr_nxt    = instr_out;
    pc_plus4_nxt = pc_plus4_out;
    id_valid_nxt = id_valid;
    imem_req     = 1'b0;

    case (state)
      BOOT: begin
        // Nothing is latched and branch_taken is ignored here.
        state_nxt = RUN;
      end
      RUN, HOLD: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          // Redirect wins over stall; the word fetched this cycle is dropped.
          pc_nxt       = branch_target;
          instr_nxt    = NOP_WORD;
          id_valid_nxt = 1'b0;
          state_nxt    = RUN;
        end else if (stall) begin
          state_nxt = HOLD;
        end else begin
          state_nxt = RUN;
          if (imem_valid) begin
            instr_nxt    = imem_rdata;
            pc_plus4_nxt = pc_inc;
            id_valid_nxt = 1'b1;
            pc_nxt       = pc_inc;
          end else begin
            // Memory wait: insert a bubble, refetch the same PC.
            instr_nxt    = NOP_WORD;
            id_valid_nxt = 1'b0;
          end
        end
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

endmodule
